// File: rtl/uart_tx_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_seq_pkg
// Description : Shared types and constants for the UART transmit sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_seq_pkg;

    localparam int unsigned c_default_divisor = 10417;
    localparam int unsigned c_data_width      = 8;
    localparam int unsigned c_idx_w           = $clog2(c_data_width);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Even parity of the byte, flipped for odd parity.
    function automatic logic parity_bit(input logic [c_data_width-1:0] data,
                                        input logic                    odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_seq_if
// Description : Byte request handshake between a requester and the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_seq_if;
    import uart_tx_seq_pkg::*;

    logic [c_data_width-1:0] tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    parity_en;
    logic                    parity_odd;
    logic                    two_stop;

    modport master (
        output tx_data,
        output tx_valid,
        output parity_en,
        output parity_odd,
        output two_stop,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  parity_en,
        input  parity_odd,
        input  two_stop,
        output tx_ready
    );

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Wrapping baud counter; tick marks the last clock of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_tx_seq_pkg::*;
#(
    parameter int unsigned DIVISOR = c_default_divisor
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned     c_cnt_w = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(DIVISOR - 1);

    logic [c_cnt_w-1:0] r_count;

    assign tick = enable && (r_count == c_max);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == c_max) ? '0 : r_count + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_seq.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_seq
// Description : UART transmitter: 8N1/8E1/8O1 with optional second stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_seq
    import uart_tx_seq_pkg::*;
#(
    parameter int unsigned DIVISOR = c_default_divisor
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_seq_if.slave  tx_req,
    output logic          tx,
    output logic          busy,
    output logic          tx_done
);

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_data_width - 1);

    tx_state_t               r_state,       w_state_next;
    logic [c_data_width-1:0] r_data,        w_data_next;
    logic [c_idx_w-1:0]      r_bit_idx,     w_idx_next;
    logic                    r_parity_en,   w_pen_next;
    logic                    r_parity_odd,  w_podd_next;
    logic                    r_two_stop,    w_two_next;
    logic                    r_stop_second, w_stop2_next;
    logic                    r_tx,          w_tx_next;
    logic                    r_tx_done,     w_done_next;

    logic w_idle;
    logic w_accept;
    logic w_tick;

    assign w_idle          = (r_state == ST_IDLE);
    assign w_accept        = tx_req.tx_valid && w_idle;
    assign tx_req.tx_ready = w_idle;
    assign busy            = !w_idle;
    assign tx              = r_tx;
    assign tx_done         = r_tx_done;

    uart_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_accept),
        .enable (!w_idle),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_idx_next   = r_bit_idx;
        w_pen_next   = r_parity_en;
        w_podd_next  = r_parity_odd;
        w_two_next   = r_two_stop;
        w_stop2_next = r_stop_second;
        w_done_next  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_START;
                    w_data_next  = tx_req.tx_data;
                    w_pen_next   = tx_req.parity_en;
                    w_podd_next  = tx_req.parity_odd;
                    w_two_next   = tx_req.two_stop;
                    w_idx_next   = '0;
                    w_stop2_next = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == c_last_idx) begin
                        w_state_next = r_parity_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_idx_next = r_bit_idx + c_idx_w'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_two_stop && !r_stop_second) begin
                        w_stop2_next = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // The line register follows the upcoming state so each bit appears
        // on the clock right after the accept or tick that enters it.
        w_tx_next = 1'b1;
        unique case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_data_next[w_idx_next];
            ST_PARITY: w_tx_next = parity_bit(w_data_next, w_podd_next);
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_data        <= '0;
            r_bit_idx     <= '0;
            r_parity_en   <= 1'b0;
            r_parity_odd  <= 1'b0;
            r_two_stop    <= 1'b0;
            r_stop_second <= 1'b0;
            r_tx          <= 1'b1;
            r_tx_done     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_data        <= w_data_next;
            r_bit_idx     <= w_idx_next;
            r_parity_en   <= w_pen_next;
            r_parity_odd  <= w_podd_next;
            r_two_stop    <= w_two_next;
            r_stop_second <= w_stop2_next;
            r_tx          <= w_tx_next;
            r_tx_done     <= w_done_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_seq
// Description : Self-checking bench for uart_tx_seq with a serial-line monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_seq;
    import uart_tx_seq_pkg::*;

    localparam int c_div = 4;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic busy;
    logic tx_done;

    uart_tx_seq_if bus ();

    uart_tx_seq #(
        .DIVISOR (c_div)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_req  (bus.slave),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       podd;
        logic       two;
        logic       pbit;
        int         len;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       pbit;
        int         len;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic exp_bit(input exp_t e, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return e.data[k-1];
        if (k == 9 && e.pen) return e.pbit;
        return 1'b1;
    endfunction

    // Line monitor: pops the expected frame at the start bit and checks
    // every clock of the frame, then tx_done / tx_ready right after it.
    logic       mon_in_frame = 1'b0;
    int         mon_idx;
    int         mon_err;
    int         mon_first_bad;
    exp_t       mon_e;
    logic [7:0] mon_data;

    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                mon_in_frame = 1'b0;
            end else begin
                if (!mon_in_frame) begin
                    if (tx_done === 1'b1) check("spurious_done", 32'd1, 32'd0);
                    if (tx === 1'b0) begin
                        if (sb_q.size() == 0) begin
                            check("unexpected_frame", 32'd1, 32'd0);
                        end else begin
                            mon_e         = sb_q.pop_front();
                            mon_in_frame  = 1'b1;
                            mon_idx       = 0;
                            mon_err       = 0;
                            mon_first_bad = -1;
                            mon_data      = 8'h00;
                        end
                    end
                end
                if (mon_in_frame) begin
                    if (mon_idx < mon_e.len) begin
                        if (tx_done === 1'b1) begin
                            check("frame_len", mon_idx, mon_e.len);
                            mon_in_frame = 1'b0;
                        end else begin
                            if (tx !== exp_bit(mon_e, mon_idx / c_div) || busy !== 1'b1) begin
                                mon_err++;
                                if (mon_first_bad < 0) mon_first_bad = mon_idx;
                            end
                            if ((mon_idx % c_div) == c_div / 2 && (mon_idx / c_div) >= 1
                                && (mon_idx / c_div) <= 8)
                                mon_data[(mon_idx / c_div) - 1] = tx;
                            mon_idx++;
                        end
                    end else begin
                        if (mon_err != 0)
                            $display("  first bad sample %0d of frame %0h", mon_first_bad, mon_e.data);
                        check("wave_errors", mon_err, 0);
                        check("data_byte", mon_data, mon_e.data);
                        check("done_at_len", tx_done, 1'b1);
                        check("ready_at_done", bus.tx_ready, 1'b1);
                        mon_in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drive(input vec_t v, input logic valid);
        bus.tx_data    = v.data;
        bus.parity_en  = v.pen;
        bus.parity_odd = v.podd;
        bus.two_stop   = v.two;
        bus.tx_valid   = valid;
    endtask

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.data = v.data;
        e.pen  = v.pen;
        e.pbit = v.pbit;
        e.len  = v.len;
        return e;
    endfunction

    // Present a byte, push its expectation, and return just after the accept edge.
    task automatic send(input vec_t v);
        int t;
        @(posedge clk); #1;
        drive(v, 1'b1);
        t = 0;
        while (!bus.tx_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check("ready_timeout", 32'd0, 32'd1);
        sb_q.push_back(to_exp(v));
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((!bus.tx_ready || mon_in_frame) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];
    vec_t v;
    int   gap;

    initial begin
        // data, pen, podd, two, expected parity bit, expected frame length
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 40};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 44};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 44};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 44};
        vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 48};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 44};
        vecs[6] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 48};
        vecs[7] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 40};

        reset = 1'b1;
        drive('{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0}, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_ready", bus.tx_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", tx_done, 1'b0);

        foreach (vecs[i]) begin
            send(vecs[i]);
            check("busy_after_accept", busy, 1'b1);
            wait_idle();
        end

        // Back-to-back with tx_valid held high across two bytes.
        @(posedge clk); #1;
        drive('{8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 40}, 1'b1);
        sb_q.push_back(to_exp('{8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 40}));
        @(posedge clk); #1;
        bus.tx_data = 8'h22;
        sb_q.push_back(to_exp('{8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 40}));
        gap = 0;
        while (!bus.tx_ready && gap < 200) begin
            @(posedge clk); #1;
            gap++;
        end
        check("b2b_ready_gap", gap, 40);
        check("b2b_done_with_ready", tx_done, 1'b1);
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        check("b2b_second_accept", bus.tx_ready, 1'b0);
        wait_idle();

        // Inputs scrambled right after the accept must not affect the frame.
        v = '{8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 44};
        send(v);
        drive('{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 0}, 1'b0);
        repeat (20) @(posedge clk);
        #1 bus.tx_data = 8'hFF;
        wait_idle();

        // Reset at clock 13 of a frame aborts it without tx_done.
        send('{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 48});
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_tx", tx, 1'b1);
        check("abort_ready", bus.tx_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", tx_done, 1'b0);
        repeat (60) @(posedge clk);
        send(vecs[7]);
        wait_idle();

        // Reset wins over a simultaneous accept.
        @(posedge clk); #1;
        reset = 1'b1;
        drive('{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 0}, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.tx_valid = 1'b0;
        @(negedge clk);
        check("rst_prio_busy", busy, 1'b0);
        check("rst_prio_tx", tx, 1'b1);
        repeat (10) @(posedge clk);

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
